// File: rtl/tdm_demux.sv
// Time-division demultiplexer: tracks the slot position of a TDM sample stream
// against a frame marker and steers each sample into a per-channel register.
module tdm_demux #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_start,
    output logic [NCH*WIDTH-1:0] ch_data,
    output logic [NCH-1:0]       ch_valid,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 locked
);

    localparam int SW = $clog2(NCH);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [NCH*WIDTH-1:0] ch_data_q, ch_data_d;
    logic [NCH-1:0]       ch_valid_q, ch_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sync_err_q, sync_err_d;
    logic                 wr_en;
    logic [SW-1:0]        wr_idx;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = '0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_start) begin
                        wr_en   = 1'b1;
                        slot_d  = SLOT_ONE;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_start) begin
                        // A marker always restarts the frame; off slot 0 it is an early marker.
                        sync_err_d = (slot_q != '0);
                        wr_en      = 1'b1;
                        slot_d     = SLOT_ONE;
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        slot_d     = '0;
                    end else begin
                        wr_en        = 1'b1;
                        wr_idx       = slot_q;
                        frame_done_d = (slot_q == SLOT_LAST);
                        slot_d       = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_ONE;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (wr_en) begin
            ch_data_d[int'(wr_idx)*WIDTH +: WIDTH] = din;
            ch_valid_d[wr_idx]                     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a time-multiplexed sample stream built from the 2:1/N:1 mux-select pattern.
- Accepts one WIDTH-bit sample per valid cycle, tracks the slot position against a frame marker, and steers each sample into a per-channel holding register with a one-cycle strobe.
- Sits between a serial TDM link and per-channel consumers. Provides frame lock and sync-error reporting.

Parameters:
- WIDTH, 2, bits per sample and per channel register.
- NCH, 4, channels (slots) per frame; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  WIDTH  multiplexed sample.
- din_valid  input  1  din carries a sample this cycle.
- frame_start  input  1  qualified by din_valid; marks the current sample as slot 0.
- ch_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- ch_valid  output  NCH  one-cycle pulse; bit k indicates channel k was just updated.
- frame_done  output  1  one-cycle pulse; slot NCH-1 was just written.
- sync_err  output  1  one-cycle pulse; frame marker mismatch detected.
- locked  output  1  high while in LOCKED state.

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a rising edge):
  - ch_data, ch_valid, frame_done, sync_err and locked go to 0.
  - FSM goes to HUNT.
  - Slot counter goes to 0.
  - Reset takes priority over every other event, including mid-frame; any partial frame is discarded.
- Slot counter: width $clog2(NCH). It advances only on accepted samples, wraps from NCH-1 to 0, and holds during din_valid-low gaps. Gaps of any length are legal.
- Latency: a sample accepted at edge N appears on ch_data and its ch_valid bit is high for exactly the cycle following edge N. Unwritten channels hold their value.
- FSM state HUNT (locked=0):
  - din_valid && frame_start: write din to channel 0, pulse ch_valid[0], set slot=1, go to LOCKED.
  - Any other valid sample: discard it; no ch_valid and no sync_err.
- FSM state LOCKED (locked=1). For each accepted sample:
  - slot==0 && frame_start: write channel 0 (normal frame start).
  - slot!=0 && !frame_start: write the channel selected by slot (normal).
  - slot!=0 && frame_start (early marker, resync):
    - Pulse sync_err.
    - Write din to channel 0 and set slot=1.
    - Stay in LOCKED.
    - frame_done is not pulsed for the truncated frame.
  - slot==0 && !frame_start (missing marker):
    - Pulse sync_err.
    - Discard the sample; no ch_valid.
    - Go to HUNT with slot=0.
- frame_done pulses in the same cycle as ch_valid[NCH-1].
- ch_valid is one-hot or zero at all times.
- frame_start without din_valid is ignored in both states.
- NCH=2 edge case: slot toggles 0/1. All rules above apply unchanged.

Test Plan:
1. Reset, then feed 4 frames with frame_start on slot 0 and din=0,1,2,3 per frame -> ch_valid pulses 0001,0010,0100,1000 one cycle after each sample; ch_data=0xE4 after frame 1; frame_done pulses 4 times; locked=1 from one cycle after the first sample; sync_err never pulses.
2. Before any marker, feed 3 valid samples (din=3), then a marker frame with din=1,2,3,0 -> first 3 samples produce no ch_valid and locked=0; after the frame, ch_data=0x39.
3. While locked, assert frame_start on slot 2 with din=3 -> sync_err pulses once; ch_valid=0001; channel 0=3; no frame_done; the next sample writes channel 1; locked stays 1.
4. While locked, omit frame_start at the slot-0 position -> sync_err pulses once, locked=0, no ch_valid for that sample, ch_data unchanged; the next marker relocks on channel 0.
5. Insert a 5-cycle din_valid gap after slot 1 -> no ch_valid during the gap; slot 2 is still written next; frame_done arrives with slot 3.
6. Drive rst_n low for one edge after slot 2 -> the next cycle shows ch_data=0, locked=0 and all pulses 0; a sample without a marker is discarded; a marker sample lands in channel 0.
